// File: rtl/clock_time_ctrl_if.sv
// Key/display bundle for the clock time controller.
//   key_mode : debounced one-cycle pulse, steps RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
//   key_inc  : debounced one-cycle pulse, increments the field being edited
//   num      : 24-bit BCD display word {hh, mm, ss}
//   mode     : current state (0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC)
//   sec_tick : one-cycle pulse per second while running
interface clock_time_ctrl_if;
  logic        key_mode;
  logic        key_inc;
  logic [23:0] num;
  logic [1:0]  mode;
  logic        sec_tick;

  modport master (output key_mode, key_inc, input num, mode, sec_tick);
  modport slave  (input key_mode, key_inc, output num, mode, sec_tick);
endinterface

// File: rtl/clock_time_ctrl.sv
// Time-keeping / time-setting controller for a 6-digit BCD clock.
// Keeps hh:mm:ss in BCD, advances once per prescaler wrap in RUN, and lets
// the user edit one field at a time with key_mode / key_inc. The field being
// edited blinks on the display word (off phase forces both nibbles to 4'hF).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of clock_time_ctrl_if (keys in; num/mode/sec_tick out)
module clock_time_ctrl #(
  parameter logic [25:0] TICK_CNT   = 26'd50_000_000,
  parameter logic [24:0] BLINK_HALF = 25'd12_500_000
) (
  input  logic               clk,
  input  logic               rst_n,
  clock_time_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;

  // Field order matches the display word layout.
  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
  } bcd_time_t;

  localparam logic [25:0] TICK_LAST  = TICK_CNT - 26'd1;
  localparam logic [25:0] BLINK_LAST = {BLINK_HALF, 1'b0} - 26'd1;
  localparam logic [25:0] BLINK_ON   = {1'b0, BLINK_HALF};

  state_t    state_q, state_d;
  bcd_time_t time_q, time_d;
  logic [25:0] pre_q, pre_d;
  logic [25:0] blink_q, blink_d;
  logic [23:0] num_q, disp;
  logic        sec_tick_q, tick;
  logic [8:0]  sc_inc, mn_inc;

  // {carry, next} for a 00..59 BCD pair.
  function automatic logic [8:0] inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 9'h100;
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // Next value for a 00..23 BCD hour.
  function automatic logic [7:0] inc24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pre_d   = 26'd0;
    blink_d = 26'd0;
    sc_inc  = inc60(time_q.sc);
    mn_inc  = inc60(time_q.mn);
    tick    = (state_q == RUN) && (pre_q == TICK_LAST);

    if (state_q == RUN && !bus.key_mode)
      pre_d = tick ? 26'd0 : pre_q + 26'd1;

    // Ripple carry only on a real tick; the whole rollover lands in one cycle.
    if (tick) begin
      time_d.sc = sc_inc[7:0];
      if (sc_inc[8]) begin
        time_d.mn = mn_inc[7:0];
        if (mn_inc[8]) time_d.hr = inc24(time_q.hr);
      end
    end

    if (bus.key_mode) begin
      // key_mode wins over a coincident key_inc; blink restarts in the on phase.
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end else if (bus.key_inc && state_q != RUN) begin
      // Field-local increment, no carry into neighbours.
      case (state_q)
        SET_HOUR: time_d.hr = inc24(time_q.hr);
        SET_MIN:  time_d.mn = mn_inc[7:0];
        default:  time_d.sc = sc_inc[7:0];
      endcase
    end else if (state_q != RUN) begin
      blink_d = (blink_q == BLINK_LAST) ? 26'd0 : blink_q + 26'd1;
    end

    disp = time_q;
    if (state_q != RUN && blink_q >= BLINK_ON) begin
      case (state_q)
        SET_HOUR: disp[23:16] = 8'hFF;
        SET_MIN:  disp[15:8]  = 8'hFF;
        default:  disp[7:0]   = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      time_q     <= '0;
      pre_q      <= '0;
      blink_q    <= '0;
      num_q      <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      pre_q      <= pre_d;
      blink_q    <= blink_d;
      num_q      <= disp;
      sec_tick_q <= tick;
    end
  end

  assign bus.num      = num_q;
  assign bus.mode     = state_q;
  assign bus.sec_tick = sec_tick_q;
endmodule
